// File: rtl/mm_pkg.sv
// Shared definitions for the sequential slice multiplier: FSM encoding and
// the slice-count constant used to size the multiplier-slice counter.
package mm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH_A = 128;
    localparam int DEF_WIDTH_B = 128;
    localparam int DEF_CHUNK   = 16;
    localparam int NUM_SLICES  = DEF_WIDTH_B / DEF_CHUNK;

    // Slice count for non-default parameterisations of the multiplier width.
    function automatic int num_slices(input int width_b, input int chunk);
        return width_b / chunk;
    endfunction

endpackage

// File: rtl/mult_partial.sv
// Combinational unsigned WIDTH_A x WIDTH_B partial-product multiplier.
module mult_partial #(
    parameter int WIDTH_A = 128,
    parameter int WIDTH_B = 16
) (
    input  logic [WIDTH_A-1:0]         a,
    input  logic [WIDTH_B-1:0]         b,
    output logic [WIDTH_A+WIDTH_B-1:0] p
);

    localparam int PW = WIDTH_A + WIDTH_B;

    assign p = PW'(a) * PW'(b);

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequential multiplier: consumes one CHUNK-bit multiplier slice per cycle,
// shift-accumulating partial products into a full-width product register.
module mult_seq_ctrl
    import mm_pkg::*;
#(
    parameter int WIDTH_A = 128,
    parameter int WIDTH_B = 128,
    parameter int CHUNK   = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH_A-1:0]         a,
    input  logic [WIDTH_B-1:0]         b,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH_A+WIDTH_B-1:0] p,
    output logic                       busy
);

    localparam int N_SLICES = num_slices(WIDTH_B, CHUNK);
    localparam int KW       = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;
    localparam int ACC_W    = WIDTH_A + WIDTH_B;
    localparam int PP_W     = WIDTH_A + CHUNK;
    localparam logic [KW-1:0] K_LAST = KW'(N_SLICES - 1);

    state_t             r_state;
    logic [WIDTH_A-1:0] r_a;
    logic [WIDTH_B-1:0] r_b;
    logic [ACC_W-1:0]   r_acc;
    logic [KW-1:0]      r_k;
    logic               r_out_valid;
    logic               r_busy;

    logic [CHUNK-1:0]   w_slices [N_SLICES];
    logic [CHUNK-1:0]   w_slice;
    logic [PP_W-1:0]    w_pp;
    logic [31:0]        w_bit_off;
    logic [ACC_W-1:0]   w_term;
    logic               w_accept;

    genvar gi;
    generate
        for (gi = 0; gi < N_SLICES; gi++) begin : g_slice
            assign w_slices[gi] = r_b[gi*CHUNK +: CHUNK];
        end
    endgenerate

    assign w_slice   = w_slices[r_k];
    assign w_bit_off = 32'(r_k) * 32'(CHUNK);

    mult_partial #(
        .WIDTH_A (WIDTH_A),
        .WIDTH_B (CHUNK)
    ) u_mult_partial (
        .a (r_a),
        .b (w_slice),
        .p (w_pp)
    );

    assign w_term = ACC_W'(w_pp) << w_bit_off;

    // DONE only frees the slot when the current product is being taken.
    assign in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign p         = r_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_k         <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_acc   <= '0;
                        r_k     <= '0;
                        r_busy  <= 1'b1;
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    r_acc <= r_acc + w_term;
                    if (r_k == K_LAST) begin
                        r_k         <= '0;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (in_valid) begin
                            r_a     <= a;
                            r_b     <= b;
                            r_acc   <= '0;
                            r_k     <= '0;
                            r_busy  <= 1'b1;
                            r_state <= CALC;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed and randomized checks of mult_seq_ctrl against a plain a*b model.
module tb_mult_seq_ctrl;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] a;
    logic [127:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] p;
    logic         busy;

    int n_checks = 0;
    int n_err    = 0;

    mult_seq_ctrl #(
        .WIDTH_A (128),
        .WIDTH_B (128),
        .CHUNK   (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [255:0] ref_mul(input logic [127:0] x, input logic [127:0] y);
        logic [255:0] wx;
        logic [255:0] wy;
        wx = {128'b0, x};
        wy = {128'b0, y};
        return wx * wy;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents operands from IDLE; returns just after the accepting edge.
    task automatic start_op(input logic [127:0] x, input logic [127:0] y);
        tick();
        a        = x;
        b        = y;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a        = rand128();
        b        = rand128();
    endtask

    task automatic wait_result(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 30) begin
            tick();
            cyc++;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("release_ovalid", out_valid, 0);
    endtask

    task automatic run_directed(input string tag, input logic [127:0] x, input logic [127:0] y);
        int cyc;
        start_op(x, y);
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_inrdy_calc"}, in_ready, 0);
        wait_result(cyc);
        chk({tag, "_latency"}, cyc, 8);
        chk({tag, "_p"}, p, ref_mul(x, y));
        release_result();
    endtask

    initial begin
        logic [255:0] p_hold;
        logic [255:0] q[$];
        logic [127:0] x;
        logic [127:0] y;
        logic         stale;
        int           cyc;
        int           sent;
        int           recv;
        int           extra;
        int           cycles;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;

        // Reset state
        #12;
        chk("rst_ovalid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_p", p, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_inready", in_ready, 1);

        // Directed corner cases
        run_directed("one", 128'd1, 128'd1);
        x = '1;
        run_directed("allones", x, x);
        y = 128'd1 << 112;
        run_directed("topslice", 128'd3, y);
        run_directed("bzero", rand128(), 128'd0);

        // Stall in DONE, then back-to-back accept on the releasing edge
        x = rand128();
        y = rand128();
        start_op(x, y);
        wait_result(cyc);
        chk("stall_latency", cyc, 8);
        p_hold = p;
        chk("stall_p0", p_hold, ref_mul(x, y));
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_ovalid", out_valid, 1);
            chk("stall_p", p, p_hold);
            chk("stall_inready", in_ready, 0);
        end
        x = rand128();
        y = rand128();
        a         = x;
        b         = y;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("b2b_inready", in_ready, 1);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = rand128();
        b         = rand128();
        chk("b2b_busy", busy, 1);
        chk("b2b_ovalid", out_valid, 0);
        wait_result(cyc);
        chk("b2b_latency", cyc, 8);
        chk("b2b_p", p, ref_mul(x, y));
        release_result();

        // Asynchronous reset mid-computation at k=4
        start_op(rand128(), rand128());
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        chk("arst_ovalid", out_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_p", p, 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            stale = stale | out_valid;
        end
        out_ready = 1'b0;
        chk("arst_no_stale", stale, 0);
        run_directed("after_rst", 128'd5, 128'd7);

        // Random stream with random handshakes
        sent   = 0;
        recv   = 0;
        extra  = 0;
        cycles = 0;
        while ((sent < 1000 || recv < 1000) && cycles < 60000) begin
            in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
            a         = rand128();
            b         = ($urandom_range(0, 15) == 0) ? 128'd0 : rand128();
            out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            if (in_valid && in_ready) begin
                q.push_back(ref_mul(a, b));
                sent++;
            end
            if (out_valid && out_ready) begin
                if (q.size() > 0) chk("stream_p", p, q.pop_front());
                else extra++;
                recv++;
            end
            tick();
            cycles++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("stream_sent", sent, 1000);
        chk("stream_recv", recv, 1000);
        chk("stream_extra", extra, 0);
        chk("stream_left", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
